// File: rtl/fram_spi_target_if.sv
// Byte-memory bus between the FRAM SPI target and its storage array.
// The target drives address, write data and strobes; the memory returns read data one clk after mem_re.
interface fram_spi_target_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/fram_spi_target.sv
// SPI mode-0 target decoding FRAM-style WREN/WRDI/RDSR/READ/WRITE commands onto a byte memory.
// SPI pins are oversampled in the clk domain; all outputs are registered.
module fram_spi_target #(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              wel,
  output logic              busy,
  fram_spi_target_if.master mem
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_RD     = 3'd3,
    ST_WR     = 3'd4,
    ST_STATUS = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  state_t            state_q;
  logic [3:0]        bit_cnt_q;
  logic [14:0]       shift_q;
  logic [7:0]        tx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              rd_cmd_q;
  logic              wr_cmd_q;
  logic              ld_pend_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic              miso_q;
  logic              miso_oe_q;
  logic              wel_q;
  logic              busy_q;

  logic        sclk_s;
  logic        cs_s;
  logic        mosi_s;
  logic        sclk_rise_s;
  logic        sclk_fall_s;
  logic        cs_rise_s;
  logic        cs_fall_s;
  logic [7:0]  rx_byte_s;
  logic [15:0] addr_full_s;

  // Synchronizer chains and edge-history flops. The cs_n chain resets low so a
  // select already held low at reset release never produces a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      cs_sync_q   <= {SYNC_STAGES{1'b0}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_s & sclk_prev_q;
  assign cs_rise_s   = cs_s & ~cs_prev_q;
  assign cs_fall_s   = ~cs_s & cs_prev_q;
  assign rx_byte_s   = {shift_q[6:0], mosi_s};
  assign addr_full_s = {shift_q, mosi_s};

  // Command/address/data sequencer with all memory and SPI outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 15'd0;
      tx_q      <= 8'd0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= 8'd0;
      rd_cmd_q  <= 1'b0;
      wr_cmd_q  <= 1'b0;
      ld_pend_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      wel_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      ld_pend_q <= mem_re_q;
      // The write strobe uses the current address; advance once it has been issued.
      if (mem_we_q) begin
        addr_q <= addr_q + ADDR_W'(1);
      end

      if (cs_rise_s) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= 4'd0;
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
        busy_q    <= 1'b0;
        wr_cmd_q  <= 1'b0;
        if (wr_cmd_q) begin
          wel_q <= 1'b0;
        end
      end else if (cs_fall_s) begin
        state_q   <= ST_CMD;
        bit_cnt_q <= 4'd0;
        busy_q    <= 1'b1;
        wr_cmd_q  <= 1'b0;
        rd_cmd_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_CMD: begin
            if (sclk_rise_s) begin
              shift_q   <= addr_full_s[14:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                case (rx_byte_s)
                  OP_WREN: begin
                    wel_q   <= 1'b1;
                    state_q <= ST_IGNORE;
                  end
                  OP_WRDI: begin
                    wel_q   <= 1'b0;
                    state_q <= ST_IGNORE;
                  end
                  OP_RDSR: begin
                    tx_q      <= {6'b000000, wel_q, 1'b0};
                    miso_oe_q <= 1'b1;
                    state_q   <= ST_STATUS;
                  end
                  OP_READ: begin
                    rd_cmd_q <= 1'b1;
                    state_q  <= ST_ADDR;
                  end
                  OP_WRITE: begin
                    wr_cmd_q <= 1'b1;
                    state_q  <= ST_ADDR;
                  end
                  default: state_q <= ST_IGNORE;
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise_s) begin
              shift_q   <= addr_full_s[14:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd15) begin
                bit_cnt_q <= 4'd0;
                addr_q    <= addr_full_s[ADDR_W-1:0];
                if (rd_cmd_q) begin
                  mem_re_q  <= 1'b1;
                  miso_oe_q <= 1'b1;
                  state_q   <= ST_RD;
                end else begin
                  state_q <= ST_WR;
                end
              end
            end
          end
          ST_RD: begin
            // Read data lands two clks after the strobe, well before the next SPI falling edge.
            if (ld_pend_q) begin
              tx_q <= mem.mem_rdata;
            end else if (sclk_fall_s) begin
              miso_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
            end else begin
              tx_q <= tx_q;
            end
            if (sclk_rise_s) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                addr_q    <= addr_q + ADDR_W'(1);
                mem_re_q  <= 1'b1;
              end
            end
          end
          ST_WR: begin
            if (sclk_rise_s) begin
              shift_q   <= addr_full_s[14:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                if (wel_q) begin
                  wdata_q  <= rx_byte_s;
                  mem_we_q <= 1'b1;
                end
              end
            end
          end
          ST_STATUS: begin
            if (sclk_fall_s) begin
              miso_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
            end
            if (sclk_rise_s) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                tx_q      <= {6'b000000, wel_q, 1'b0};
              end
            end
          end
          ST_IGNORE: state_q <= ST_IGNORE;
          ST_IDLE:   state_q <= ST_IDLE;
          default:   state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi_miso       = miso_q;
  assign spi_miso_oe    = miso_oe_q;
  assign wel            = wel_q;
  assign busy           = busy_q;
  assign mem.mem_addr   = addr_q;
  assign mem.mem_wdata  = wdata_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_re     = mem_re_q;

endmodule

// File: tb/tb_fram_spi_target.sv
// Directed bench for fram_spi_target: drives SPI mode-0 transactions and checks
// memory strobes, MISO data, WEL handling and reset behaviour against hand-computed values.
module tb_fram_spi_target;
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst_n;
  logic spi_clk, spi_cs_n, spi_mosi;
  logic spi_miso, spi_miso_oe, wel, busy;
  logic [7:0] rdata_r;

  fram_spi_target_if #(.ADDR_W(16)) mem_bus ();

  fram_spi_target #(.ADDR_W(16), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_clk     (spi_clk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .wel         (wel),
    .busy        (busy),
    .mem         (mem_bus.master)
  );

  always #5 clk = ~clk;

  // Memory model: preloaded bytes, read data registered one clk after mem_re.
  function automatic logic [7:0] mem_model(input logic [15:0] a);
    if (a == 16'h0100) return 8'h12;
    else if (a == 16'h0101) return 8'h34;
    else return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (mem_bus.mem_re) rdata_r <= mem_model(mem_bus.mem_addr);
  end
  assign mem_bus.mem_rdata = rdata_r;

  logic [15:0] we_addr[$];
  logic [7:0]  we_data[$];
  logic [15:0] re_addr[$];
  int rule_err = 0;
  int oe_cnt = 0;
  logic we_prev = 1'b0;
  logic re_prev = 1'b0;

  // Bus monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_bus.mem_we) begin
      we_addr.push_back(mem_bus.mem_addr);
      we_data.push_back(mem_bus.mem_wdata);
    end
    if (mem_bus.mem_re) re_addr.push_back(mem_bus.mem_addr);
    if (mem_bus.mem_we && mem_bus.mem_re) rule_err++;
    if (mem_bus.mem_we && we_prev) rule_err++;
    if (mem_bus.mem_re && re_prev) rule_err++;
    if (!spi_miso_oe && spi_miso) rule_err++;
    if (spi_miso_oe) oe_cnt++;
    we_prev = mem_bus.mem_we;
    re_prev = mem_bus.mem_re;
  end

  int n_cmp = 0;
  int n_mis = 0;
  int re_at_last = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      #(HALF);
      rx[i] = spi_miso;
      if (i == 0) re_at_last = re_addr.size();
      spi_clk = 1'b1;
      #(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] dummy;
    spi_bits(b, 8, dummy);
  endtask

  task automatic cs_low;
    spi_cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic cs_high;
    #(HALF);
    spi_cs_n = 1'b1;
    #(HALF * 2);
  endtask

  task automatic one_cmd(input logic [7:0] op);
    cs_low();
    send(op);
    cs_high();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pins"}, 32'({spi_miso, spi_miso_oe, mem_bus.mem_we, mem_bus.mem_re, wel, busy}), 32'd0);
    check_eq({tag, "_addr"}, 32'(mem_bus.mem_addr), 32'd0);
    check_eq({tag, "_wdata"}, 32'(mem_bus.mem_wdata), 32'd0);
  endtask

  initial begin
    logic [7:0] d0, d1;
    int w0, r0, o0;
    rst_n = 1'b0;
    spi_cs_n = 1'b1;
    spi_clk = 1'b0;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #(HALF * 2);

    // WREN then two-byte write at 0x0010
    cs_low();
    check_eq("busy_in_cs", 32'(busy), 32'd1);
    send(8'h06);
    cs_high();
    check_eq("wel_after_wren", 32'(wel), 32'd1);
    check_eq("busy_after_cs", 32'(busy), 32'd0);
    w0 = we_addr.size();
    cs_low();
    send(8'h02); send(8'h00); send(8'h10); send(8'hA5); send(8'h5A);
    cs_high();
    check_eq("wr_count", 32'(we_addr.size() - w0), 32'd2);
    if (we_addr.size() >= w0 + 2) begin
      check_eq("wr0_addr", 32'(we_addr[w0]), 32'h0010);
      check_eq("wr0_data", 32'(we_data[w0]), 32'hA5);
      check_eq("wr1_addr", 32'(we_addr[w0+1]), 32'h0011);
      check_eq("wr1_data", 32'(we_data[w0+1]), 32'h5A);
    end
    check_eq("wel_cleared_by_write", 32'(wel), 32'd0);

    // Write without WREN is dropped
    w0 = we_addr.size();
    cs_low();
    send(8'h02); send(8'h00); send(8'h20); send(8'hFF);
    cs_high();
    check_eq("wr_no_wel_count", 32'(we_addr.size() - w0), 32'd0);
    check_eq("wr_no_wel_wel", 32'(wel), 32'd0);

    // Read stream from 0x0100
    r0 = re_addr.size();
    o0 = oe_cnt;
    cs_low();
    send(8'h03); send(8'h01); send(8'h00);
    spi_bits(8'h00, 8, d0);
    spi_bits(8'h00, 8, d1);
    cs_high();
    check_eq("rd_byte0", 32'(d0), 32'h12);
    check_eq("rd_byte1", 32'(d1), 32'h34);
    check_eq("rd_re_pulses", 32'(re_at_last - r0), 32'd2);
    if (re_addr.size() >= r0 + 2) begin
      check_eq("rd_re0_addr", 32'(re_addr[r0]), 32'h0100);
      check_eq("rd_re1_addr", 32'(re_addr[r0+1]), 32'h0101);
    end
    check_eq("rd_oe_seen", 32'(oe_cnt > o0), 32'd1);
    check_eq("rd_oe_off", 32'(spi_miso_oe), 32'd0);

    // Address wrap at 0xFFFF
    one_cmd(8'h06);
    w0 = we_addr.size();
    cs_low();
    send(8'h02); send(8'hFF); send(8'hFF); send(8'h11); send(8'h22);
    cs_high();
    check_eq("wrap_count", 32'(we_addr.size() - w0), 32'd2);
    if (we_addr.size() >= w0 + 2) begin
      check_eq("wrap0_addr", 32'(we_addr[w0]), 32'hFFFF);
      check_eq("wrap0_data", 32'(we_data[w0]), 32'h11);
      check_eq("wrap1_addr", 32'(we_addr[w0+1]), 32'h0000);
      check_eq("wrap1_data", 32'(we_data[w0+1]), 32'h22);
    end

    // Status register with and without WEL, repeated bytes
    one_cmd(8'h06);
    cs_low();
    send(8'h05);
    spi_bits(8'h00, 8, d0);
    spi_bits(8'h00, 8, d1);
    cs_high();
    check_eq("rdsr_wel1_b0", 32'(d0), 32'h02);
    check_eq("rdsr_wel1_b1", 32'(d1), 32'h02);
    check_eq("rdsr_keeps_wel", 32'(wel), 32'd1);
    one_cmd(8'h04);
    check_eq("wel_after_wrdi", 32'(wel), 32'd0);
    cs_low();
    send(8'h05);
    spi_bits(8'h00, 8, d0);
    cs_high();
    check_eq("rdsr_wel0", 32'(d0), 32'h00);

    // Unknown opcode: no drive, no accesses
    o0 = oe_cnt;
    r0 = re_addr.size();
    w0 = we_addr.size();
    cs_low();
    send(8'h9F); send(8'hA5); send(8'h3C);
    cs_high();
    check_eq("ignore_oe", 32'(oe_cnt - o0), 32'd0);
    check_eq("ignore_mem", 32'((re_addr.size() - r0) + (we_addr.size() - w0)), 32'd0);

    // Write aborted after four data bits
    one_cmd(8'h06);
    w0 = we_addr.size();
    cs_low();
    send(8'h02); send(8'h00); send(8'h30);
    spi_bits(8'hF0, 4, d0);
    cs_high();
    check_eq("abort_wr_count", 32'(we_addr.size() - w0), 32'd0);
    check_eq("abort_wr_wel", 32'(wel), 32'd0);

    // Reset mid-read, select held low across release
    one_cmd(8'h06);
    cs_low();
    send(8'h03); send(8'h01); send(8'h00);
    spi_bits(8'h00, 4, d0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midrd_reset");
    rst_n = 1'b1;
    r0 = re_addr.size();
    o0 = oe_cnt;
    spi_bits(8'h00, 4, d0);
    send(8'h05);
    send(8'h00);
    check_eq("post_rst_re", 32'(re_addr.size() - r0), 32'd0);
    check_eq("post_rst_oe", 32'(oe_cnt - o0), 32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    cs_high();
    cs_low();
    send(8'h05);
    spi_bits(8'h00, 8, d0);
    cs_high();
    check_eq("post_rst_rdsr", 32'(d0), 32'h00);

    check_eq("protocol_rules", 32'(rule_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/fram_spi_target.md
FRAM_SPI_TARGET -- requirements
Module: fram_spi_target

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory byte-address width carried in the SPI address phase.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on spi_clk, spi_cs_n and spi_mosi.
REQ-003 SHALL have port clk  input  1  system clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports spi_clk, spi_cs_n, spi_mosi  input  1 each  SPI mode 0 from initiator, asynchronous to clk.
REQ-006 SHALL have ports spi_miso  output  1  serial read data; spi_miso_oe  output  1  high while a read or status phase is driving.
REQ-007 SHALL have ports mem_addr  output  ADDR_W; mem_wdata  output  8; mem_we  output  1; mem_re  output  1  byte-memory port.
REQ-008 SHALL have port mem_rdata  input  8  valid exactly one clk after the mem_re pulse.
REQ-009 SHALL have ports wel  output  1  write-enable latch; busy  output  1  high while synchronized spi_cs_n is low.

Function
REQ-010 SHALL synchronize inputs through SYNC_STAGES flops; edges are detected on synchronized spi_clk; spi_clk period SHALL be at least 8 clk periods.
REQ-011 SHALL sample spi_mosi MSB-first on detected rising edges and update spi_miso on detected falling edges.
REQ-012 SHALL, on synchronized spi_cs_n falling, enter ST_CMD with a bit counter of 0.
REQ-013 ST_CMD: after 8 bits decode opcode: 0x06 WREN sets wel; 0x04 WRDI clears wel; 0x05 -> ST_STATUS; 0x03 -> ST_ADDR(read); 0x02 -> ST_ADDR(write); any other -> ST_IGNORE.
REQ-014 ST_ADDR SHALL shift 16 bits, MSB-first; the low ADDR_W bits form the start address; upper bits are ignored.
REQ-015 Read: on the rising edge sampling the last address bit, SHALL pulse mem_re for 1 clk with mem_addr = address and enter ST_RD.
REQ-016 ST_RD: mem_rdata SHALL be loaded into the TX shifter before the next detected falling edge; bit 7 drives on that edge.
REQ-017 ST_RD: on the rising edge sampling bit 0 of each byte, SHALL increment the address and pulse mem_re, giving an unbroken byte stream.
REQ-018 Write: enter ST_WR after the address; after each 8 sampled bits, when wel=1, SHALL pulse mem_we 1 clk with current mem_addr and mem_wdata, then increment the address.
REQ-019 Write with wel=0 SHALL shift data but produce no mem_we pulses.
REQ-020 Address increment SHALL wrap from 2^ADDR_W-1 to 0.
REQ-021 ST_STATUS SHALL shift out {6'b0, wel, 1'b0} and repeat it for every further byte.
REQ-022 ST_IGNORE SHALL hold spi_miso_oe=0 and issue no memory accesses until spi_cs_n rises.
REQ-023 spi_miso_oe SHALL be 1 only in ST_RD and ST_STATUS, and spi_miso SHALL be 0 whenever spi_miso_oe is 0.
REQ-024 Synchronized spi_cs_n rising SHALL, from any state, return to idle in the same clk.
REQ-025 On that return to idle, any partial byte SHALL be discarded with no mem_we pulse; a completed mem_we already issued stands.
REQ-026 wel SHALL clear on spi_cs_n rising after a WRITE (0x02) transaction, and be unaffected by other commands.
REQ-027 mem_we and mem_re SHALL never be asserted in the same cycle, and each pulse SHALL last exactly 1 clk.

Reset
REQ-028 While rst_n=0, SHALL hold outputs at: spi_miso=0, spi_miso_oe=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, wel=0, busy=0; state idle, counters 0.
REQ-029 Reset asserted mid-transaction SHALL abort it, lose wel, and require a fresh spi_cs_n falling edge before decoding.
REQ-030 After reset release with spi_cs_n already low, SHALL stay idle until spi_cs_n goes high then low.

Verification
REQ-031 WREN; WRITE addr 0x0010 data 0xA5,0x5A -> mem_we pulses at 0x0010=0xA5 and 0x0011=0x5A; wel=0 after CS high.
REQ-032 WRITE without WREN, addr 0x0020 data 0xFF -> no mem_we; wel stays 0.
REQ-033 Memory preloaded 0x0100=0x12, 0x0101=0x34; READ addr 0x0100 for 16 clocks -> MISO 0x12 then 0x34; two mem_re pulses.
REQ-034 ADDR_W=16; WREN; WRITE addr 0xFFFF data 0x11,0x22 -> writes at 0xFFFF then 0x0000.
REQ-035 WREN; RDSR -> MISO 0x02; WRDI; RDSR -> MISO 0x00; unknown opcode 0x9F -> spi_miso_oe stays 0.
REQ-036 WREN; WRITE with CS raised after 4 data bits -> no mem_we; rst_n pulse mid-READ -> all outputs are reset values and no further mem_re.
